// File: rtl/coproc_sram_pkg.sv
// Shared definitions for the coprocessor firmware/data SRAM and the agents
// that write it: loader FSM states, geometry and byte-lane width.
package coproc_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILL,
        ST_WRITE,
        ST_FINISH
    } loader_state_t;

    localparam int SRAM_DEPTH  = 2560;
    localparam int SRAM_ADDR_W = 12;
    localparam int SRAM_BYTES  = 10240;
    localparam int SRAM_BE_W   = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: steers each loaded byte into the next
// lane and records its byte enable until cleared.
module byte_packer
    import coproc_sram_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic [7:0]               byte_data,
    output logic [1:0]               lane_idx,
    output logic [SRAM_BE_W*8-1:0]   word_data,
    output logic [SRAM_BE_W-1:0]     byte_en
);

    logic [1:0] idx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg <= '0;
        end else if (clear) begin
            idx_reg <= '0;
        end else if (load) begin
            idx_reg <= idx_reg + 1'b1;
        end
    end

    assign lane_idx = idx_reg;

    // Clear wins over load so a byte arriving with an abort is dropped.
    for (genvar gi = 0; gi < SRAM_BE_W; gi++) begin : g_lane
        logic [7:0] byte_reg;
        logic       en_reg;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                byte_reg <= '0;
                en_reg   <= 1'b0;
            end else if (clear) begin
                byte_reg <= '0;
                en_reg   <= 1'b0;
            end else if (load && idx_reg == 2'(gi)) begin
                byte_reg <= byte_data;
                en_reg   <= 1'b1;
            end
        end

        assign word_data[gi*8 +: 8] = byte_reg;
        assign byte_en[gi]          = en_reg;
    end

endmodule

// File: rtl/sram_byte_loader.sv
// Avalon-MM write master that packs an 8-bit valid/ready stream into 32-bit
// words and writes them to consecutive SRAM word addresses.
module sram_byte_loader
    import coproc_sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DEPTH  = SRAM_DEPTH,
    parameter int CNT_W  = $clog2(SRAM_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     byte_count,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [ADDR_W-1:0]    m_address,
    output logic [SRAM_BE_W-1:0] m_byteenable,
    output logic                 m_chipselect,
    output logic                 m_write,
    output logic [31:0]          m_writedata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_W:0]      words_written
);

    loader_state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic [ADDR_W:0]   words_reg;
    logic              write_reg, busy_reg, done_reg, err_reg;
    logic              accept, pack_clear, range_bad;
    logic [1:0]        lane_idx;
    logic [CNT_W+1:0]  end_byte;

    // One-past-last byte offset of the transfer, in SRAM byte units.
    assign end_byte  = ((CNT_W+2)'(addr_reg) << 2) + (CNT_W+2)'(remaining_reg);
    assign range_bad = (addr_reg >= ADDR_W'(DEPTH)) || (end_byte > (CNT_W+2)'(DEPTH * 4));

    assign s_ready = (state_reg == ST_FILL);
    assign accept  = s_ready && s_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_CHECK;
            ST_CHECK: begin
                if (abort)                       state_next = ST_IDLE;
                else if (remaining_reg == '0)    state_next = ST_FINISH;
                else if (range_bad)              state_next = ST_FINISH;
                else                             state_next = ST_FILL;
            end
            ST_FILL: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (accept && (lane_idx == 2'd3 || remaining_reg == CNT_W'(1)))
                    state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)                       state_next = ST_IDLE;
                else if (remaining_reg != '0)    state_next = ST_FILL;
                else                             state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        pack_clear = (state_next == ST_IDLE) || (state_reg == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            words_reg     <= '0;
            write_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            write_reg <= (state_next == ST_WRITE);
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_FINISH);
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg      <= base_addr;
                        remaining_reg <= byte_count;
                        words_reg     <= '0;
                        err_reg       <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (!abort && remaining_reg != '0 && range_bad)
                        err_reg <= 1'b1;
                end
                ST_FILL: begin
                    if (accept)
                        remaining_reg <= remaining_reg - 1'b1;
                end
                ST_WRITE: begin
                    // A write on the bus completes even when aborted, so count it.
                    addr_reg  <= addr_reg + 1'b1;
                    words_reg <= words_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    byte_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (pack_clear),
        .load      (accept),
        .byte_data (s_data),
        .lane_idx  (lane_idx),
        .word_data (m_writedata),
        .byte_en   (m_byteenable)
    );

    assign m_address     = addr_reg;
    assign m_chipselect  = write_reg;
    assign m_write       = write_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign words_written = words_reg;

endmodule

// File: doc/sram_byte_loader.md
# sram_byte_loader

Avalon-MM write master that fills the coprocessor's on-chip firmware/data SRAM (32-bit words, 12-bit word address, 2560 words, byte enables, no waitrequest) from an 8-bit valid/ready byte stream, such as the host link receiver. It packs bytes little-endian into 32-bit words and issues single-cycle writes at consecutive word addresses. A final partial word is written with the matching byte enables. It sits directly upstream of the SRAM write port; the system mux gives it the port while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 12: SRAM word-address width.
- `DEPTH`, 2560: SRAM depth in words; legal word addresses are 0..DEPTH-1.
- `CNT_W`, 14: byte-count width; must hold DEPTH*4 = 10240.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; starts a transfer, sampled only in IDLE.
- `abort`  in  1  pulse; cancels the current transfer.
- `base_addr`  in  ADDR_W  first word address, latched on `start`.
- `byte_count`  in  CNT_W  number of bytes to load, latched on `start`.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  stream byte is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `m_address`  out  ADDR_W  SRAM word address.
- `m_byteenable`  out  4  lane enables; lane 0 = bits 7:0.
- `m_chipselect`  out  1  SRAM select.
- `m_write`  out  1  SRAM write strobe.
- `m_writedata`  out  32  packed word.
- `busy`  out  1  transfer in progress; owns the SRAM port.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky range error; cleared by the next accepted `start`.
- `words_written`  out  ADDR_W+1  writes issued in the current or last transfer.

## Operation
- States: IDLE, CHECK, FILL, WRITE, FINISH.
- IDLE
  - `start`=1 latches `base_addr` and `byte_count`, clears `err` and `words_written`, and goes to CHECK.
- CHECK (one cycle)
  - If `byte_count`==0: go to FINISH, no error.
  - Else if `base_addr`>=DEPTH, or `base_addr`*4 + `byte_count` > DEPTH*4: set `err` and go to FINISH; no write is issued.
  - Else go to FILL with lane index 0 and `remaining`=`byte_count`.
- FILL
  - `s_ready`=1.
  - On each `s_valid`&`s_ready`, the byte goes into lane[idx], byte-enable bit idx is set, idx increments and `remaining` decrements.
  - When idx reaches 4, or `remaining` reaches 0, go to WRITE.
- WRITE (exactly one cycle)
  - Drives `m_chipselect`=`m_write`=1 with the packed data and accumulated enables. The SRAM has no waitrequest, so the write always completes in this cycle.
  - `s_ready`=0.
  - Then: address increments, `words_written` increments, lanes and enables clear.
  - Go to FILL if `remaining`>0, else FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `abort` in CHECK, FILL or WRITE goes directly to IDLE. A word captured in FILL is discarded. A WRITE already on the bus that cycle completes. No `done` pulse.
- `start` outside IDLE is ignored.
- Unused lanes of `m_writedata` are driven with 0.

## Timing
- Reset values: state=IDLE, every output 0 except `m_address`=0; internal counters and lanes are 0.
- All outputs are registered except `s_ready`, which decodes the state register directly.
- Latencies:
  - `start` to first `s_ready`: 2 cycles.
  - Fourth byte accepted to write on bus: the next cycle.
  - Last write to `done`: the next cycle.
- Throughput: at most 4 bytes per 5 cycles. `s_valid` gaps stall FILL without limit.
- `busy`=1 in CHECK, FILL, WRITE and FINISH.
- `m_address` wraps never: CHECK guarantees the last write address <= DEPTH-1.
- Reset asserted mid-transfer returns to IDLE immediately and drops the write strobe asynchronously. The SRAM word being written is undefined.

## Structure
- Shared package `coproc_sram_pkg`:
  - state enum;
  - `SRAM_DEPTH`=2560, `SRAM_ADDR_W`=12, `SRAM_BYTES`=10240;
  - byte-enable width constant, shared with the SRAM wrapper and the port mux.
- Optional sub-module `byte_packer`: lane index, data/enable accumulation and clear. The FSM and range check stay in the top module.

## Test plan
- base 0x010, count 8, bytes 01..08 → writes 0x04030201 @0x010 be 0xF, then 0x08070605 @0x011 be 0xF; `done` one cycle later; `words_written`=2; `err`=0.
- base 0x000, count 5, bytes AA BB CC DD EE → 0xDDCCBBAA @0x000 be 0xF, then 0x000000EE @0x001 be 0x1.
- base 0x9FF, count 5 → `err`=1, no `m_write` ever, `done` pulse; count 0 → `done`, `err`=0, no write.
- Random `s_valid` gaps with count 12 → identical write sequence to the gap-free run; `s_ready`=0 in every WRITE cycle.
- `abort` after 2 bytes of word 2 (count 8) → one write only, IDLE next cycle, no `done`; `start` while busy is ignored.
- `reset_n` low during FILL → all outputs 0 without waiting for a clock edge; a fresh `start` after release runs normally.
